arp_test_top: RTL and testbench

//  GMII-domain ARP request generator and board bring-up logic.

---
 rtl/arp_test_pkg.sv | 46 ++++
 rtl/crc32_d8.sv | 29 ++
 rtl/arp_test_top.sv | 161 ++++++++++++++++
 tb/tb_arp_test_top.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arp_test_pkg.sv
// ============================================================================
// Module  : arp_test_pkg
// Brief   : Shared types, constants and frame builder for the ARP test block.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package arp_test_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PRE  = 3'd1,
      ST_DATA = 3'd2,
      ST_FCS  = 3'd3,
      ST_IFG  = 3'd4
   } arp_state_t;

   localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;
   localparam logic [15:0] ARP_OPER_REQ = 16'h0001;
   localparam logic [31:0] CRC_POLY     = 32'hEDB88320;

   localparam int PREAMBLE_LEN = 8;
   localparam int PAYLOAD_LEN  = 60;
   localparam int FCS_LEN      = 4;

   // Returns the 60-byte broadcast ARP request with byte 0 in bits [7:0].
   function automatic logic [PAYLOAD_LEN*8-1:0] arp_payload(
      input logic [47:0] mac,
      input logic [31:0] sender_ip,
      input logic [31:0] target_ip
   );
      logic [PAYLOAD_LEN*8-1:0] msb_first;
      logic [PAYLOAD_LEN*8-1:0] lsb_first;
      msb_first = {48'hFFFF_FFFF_FFFF, mac, ETH_TYPE_ARP,
                   16'h0001, 16'h0800, 8'h06, 8'h04, ARP_OPER_REQ,
                   mac, sender_ip, 48'h0, target_ip, 144'h0};
      lsb_first = '0;
      for (int i = 0; i < PAYLOAD_LEN; i++) begin
         lsb_first[8*i +: 8] = msb_first[PAYLOAD_LEN*8-1-8*i -: 8];
      end
      return lsb_first;
   endfunction

endpackage

`default_nettype wire

// File: rtl/crc32_d8.sv
// ============================================================================
// Module  : crc32_d8
// Brief   : Byte-parallel reflected CRC-32 next-state function.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module crc32_d8
   import arp_test_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  d,
   output logic [31:0] crc_out
);

   logic [31:0] w_crc;

   // Data enters LSB first, matching the Ethernet bit order.
   always_comb begin
      w_crc = crc_in;
      for (int i = 0; i < 8; i++) begin
         w_crc = (w_crc >> 1) ^ (((w_crc[0] ^ d[i]) != 1'b0) ? CRC_POLY : 32'h0);
      end
      crc_out = w_crc;
   end

endmodule

`default_nettype wire

// File: rtl/arp_test_top.sv
// ============================================================================
// Module  : arp_test_top
// Brief   : GMII ARP request generator with PHY reset sequencing.
//           ARP_PERIODIC_EN: repeat frames every SEND_PERIOD_CYC, else one per reset.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module arp_test_top
   import arp_test_pkg::*;
#(
   parameter logic [47:0] LOCAL_MAC       = 48'h000A3501FEC0,
   parameter logic [31:0] LOCAL_IP        = 32'hC0A80002,
   parameter logic [31:0] TARGET_IP       = 32'hC0A80003,
   parameter int          PHY_RST_CYC     = 1250,
   parameter int          SEND_PERIOD_CYC = 125000,
   parameter int          IFG_CYC         = 12
) (
   input  logic       userclk2,
   input  logic       sys_rst_n,
   input  logic       resetdone,
   input  logic       link_up,
   output logic       phy_rst_n,
   output logic       led_link,
   output logic [7:0] test_gmii_tx_data,
   output logic       test_gmii_tx_en,
   output logic       test_gmii_tx_err
);

   localparam logic [PAYLOAD_LEN*8-1:0] c_PAYLOAD = arp_payload(LOCAL_MAC, LOCAL_IP, TARGET_IP);
   localparam logic [7:0]  c_PRE_LAST    = 8'(PREAMBLE_LEN - 1);
   localparam logic [7:0]  c_DATA_LAST   = 8'(PAYLOAD_LEN - 1);
   localparam logic [7:0]  c_FCS_LAST    = 8'(FCS_LEN - 1);
   localparam logic [7:0]  c_IFG_LAST    = 8'(IFG_CYC - 1);
   localparam logic [31:0] c_PHY_LAST    = 32'(PHY_RST_CYC - 1);
   localparam logic [31:0] c_PERIOD_LOAD = 32'(SEND_PERIOD_CYC - 1);

   arp_state_t  r_state;
   arp_state_t  w_state_next;
   logic [7:0]  r_cnt;
   logic [31:0] r_phy_cnt;
   logic        r_phy_rst_n;
   logic [31:0] r_period_cnt;
   logic [31:0] r_crc;
   logic [31:0] w_crc_next;
   logic        r_led;
   logic        w_go;
   logic        w_start;
   logic [7:0]  w_tx_data;
   logic [7:0]  w_data_byte;
   logic [7:0]  w_fcs_byte;

   assign w_data_byte = 8'(c_PAYLOAD >> {r_cnt[5:0], 3'b000});
   assign w_fcs_byte  = 8'(r_crc >> {r_cnt[1:0], 3'b000});
   assign w_start     = (r_state == ST_IDLE) && (w_state_next == ST_PRE);

`ifdef ARP_PERIODIC_EN
   assign w_go = r_phy_rst_n && resetdone && (r_period_cnt == 32'd0);
`else
   logic r_sent;

   always_ff @(posedge userclk2 or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_sent <= 1'b0;
      end else if (w_start) begin
         r_sent <= 1'b1;
      end
   end

   assign w_go = r_phy_rst_n && resetdone && (r_period_cnt == 32'd0) && !r_sent;
`endif

   always_ff @(posedge userclk2 or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_phy_cnt   <= 32'd0;
         r_phy_rst_n <= 1'b0;
      end else if (!r_phy_rst_n) begin
         if (r_phy_cnt == c_PHY_LAST) begin
            r_phy_rst_n <= 1'b1;
         end else begin
            r_phy_cnt <= r_phy_cnt + 32'd1;
         end
      end
   end

   always_ff @(posedge userclk2 or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_tx_data    = 8'h00;
      case (r_state)
         ST_IDLE: begin
            if (w_go) w_state_next = ST_PRE;
         end
         ST_PRE: begin
            w_tx_data = (r_cnt == c_PRE_LAST) ? 8'hD5 : 8'h55;
            if (r_cnt == c_PRE_LAST) w_state_next = ST_DATA;
         end
         ST_DATA: begin
            w_tx_data = w_data_byte;
            if (r_cnt == c_DATA_LAST) w_state_next = ST_FCS;
         end
         ST_FCS: begin
            w_tx_data = ~w_fcs_byte;
            if (r_cnt == c_FCS_LAST) w_state_next = ST_IFG;
         end
         ST_IFG: begin
            if (r_cnt == c_IFG_LAST) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   crc32_d8 u_crc (
      .crc_in  (r_crc),
      .d       (w_tx_data),
      .crc_out (w_crc_next)
   );

   // Period counter loads on frame start so frame starts are exactly one period apart.
   always_ff @(posedge userclk2 or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_cnt        <= 8'd0;
         r_period_cnt <= 32'd0;
         r_crc        <= 32'hFFFF_FFFF;
         r_led        <= 1'b0;
      end else begin
         r_led <= link_up;
         if ((w_state_next != r_state) || (r_state == ST_IDLE)) begin
            r_cnt <= 8'd0;
         end else begin
            r_cnt <= r_cnt + 8'd1;
         end
         if (w_start) begin
            r_period_cnt <= c_PERIOD_LOAD;
         end else if (r_period_cnt != 32'd0) begin
            r_period_cnt <= r_period_cnt - 32'd1;
         end
         if (r_state == ST_PRE) begin
            r_crc <= 32'hFFFF_FFFF;
         end else if (r_state == ST_DATA) begin
            r_crc <= w_crc_next;
         end
      end
   end

   assign phy_rst_n         = r_phy_rst_n;
   assign led_link          = r_led;
   assign test_gmii_tx_data = w_tx_data;
   assign test_gmii_tx_en   = (r_state == ST_PRE) || (r_state == ST_DATA) || (r_state == ST_FCS);
   assign test_gmii_tx_err  = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_arp_test_top.sv
// ============================================================================
// Module  : tb_arp_test_top
// Brief   : Directed self-checking bench for arp_test_top.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_arp_test_top;

   localparam int PHY_RST   = 1250;
   localparam int PERIOD    = 200;
   localparam int IFG       = 12;
   localparam int FRAME_LEN = 72;

   logic       userclk2  = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       resetdone = 1'b0;
   logic       link_up   = 1'b0;
   logic       phy_rst_n;
   logic       led_link;
   logic [7:0] test_gmii_tx_data;
   logic       test_gmii_tx_en;
   logic       test_gmii_tx_err;

   arp_test_top #(
      .LOCAL_MAC       (48'h000A3501FEC0),
      .LOCAL_IP        (32'hC0A80002),
      .TARGET_IP       (32'hC0A80003),
      .PHY_RST_CYC     (PHY_RST),
      .SEND_PERIOD_CYC (PERIOD),
      .IFG_CYC         (IFG)
   ) dut (
      .userclk2          (userclk2),
      .sys_rst_n         (sys_rst_n),
      .resetdone         (resetdone),
      .link_up           (link_up),
      .phy_rst_n         (phy_rst_n),
      .led_link          (led_link),
      .test_gmii_tx_data (test_gmii_tx_data),
      .test_gmii_tx_en   (test_gmii_tx_en),
      .test_gmii_tx_err  (test_gmii_tx_err)
   );

   always #4 userclk2 = ~userclk2;

   int cyc = 0;
   always @(posedge userclk2) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   logic [7:0]   cap [0:127];
   logic [7:0]   ref_frame [0:FRAME_LEN-1];
   logic [7:0]   exp_payload [0:59];
   int           cap_len;
   int           cap_start;
   int           cap_end;
   bit           cap_err;

   task automatic build_expected();
      logic [479:0] v;
      v = {48'hFFFFFFFFFFFF, 48'h000A3501FEC0, 16'h0806, 16'h0001, 16'h0800,
           8'h06, 8'h04, 16'h0001, 48'h000A3501FEC0, 32'hC0A80002,
           48'h000000000000, 32'hC0A80003, 144'h0};
      for (int i = 0; i < 60; i++) exp_payload[i] = v[479-8*i -: 8];
   endtask

   function automatic logic [31:0] sw_fcs();
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < 60; i++) begin
         c = c ^ {24'h0, exp_payload[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   // Waits up to budget cycles for tx_en, then records bytes while tx_en stays high.
   task automatic capture_frame(input int budget, input int drop_at, output bit ok);
      ok      = 1'b0;
      cap_len = 0;
      cap_err = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge userclk2);
         if (test_gmii_tx_en) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) return;
      cap_start = cyc;
      while (test_gmii_tx_en && cap_len < 128) begin
         cap[cap_len] = test_gmii_tx_data;
         if (test_gmii_tx_err !== 1'b0) cap_err = 1'b1;
         if (cap_len == drop_at) resetdone = 1'b0;
         cap_len++;
         @(negedge userclk2);
      end
      cap_end = cyc;
   endtask

   // Pulses reset and returns the posedge count after release at which phy_rst_n rose.
   task automatic reset_release(input bit rd_at_1us, output int phy_k);
      @(negedge userclk2);
      sys_rst_n = 1'b0;
      repeat (3) @(negedge userclk2);
      sys_rst_n = 1'b1;
      phy_k = -1;
      for (int k = 1; k <= 2000; k++) begin
         @(negedge userclk2);
         if (rd_at_1us && k == 125) resetdone = 1'b1;
         if (phy_rst_n === 1'b1) begin
            phy_k = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0;
      resetdone = 1'b0;
      link_up   = 1'b1;
      repeat (5) @(negedge userclk2);
      checks++; if (phy_rst_n !== 1'b0) begin errors++; $display("FAIL reset_phy_rst_n: got %b want 0", phy_rst_n); end
      checks++; if (led_link !== 1'b0) begin errors++; $display("FAIL reset_led_link: got %b want 0", led_link); end
      checks++; if (test_gmii_tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", test_gmii_tx_data); end
      checks++; if (test_gmii_tx_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en: got %b want 0", test_gmii_tx_en); end
      checks++; if (test_gmii_tx_err !== 1'b0) begin errors++; $display("FAIL reset_tx_err: got %b want 0", test_gmii_tx_err); end
      link_up = 1'b0;
   endtask

   task automatic test_first_frame();
      int k;
      int c0;
      bit ok;
      reset_release(1'b1, k);
      c0 = cyc;
      checks++; if (k != PHY_RST) begin errors++; $display("FAIL phy_release_cycle: got %0d want %0d", k, PHY_RST); end
      checks++; if (test_gmii_tx_en !== 1'b0) begin errors++; $display("FAIL tx_en_at_phy_release: got %b want 0", test_gmii_tx_en); end
      capture_frame(5, -1, ok);
      checks++; if (!ok || cap_start != c0 + 1) begin errors++; $display("FAIL first_frame_start: got ok=%0d start=%0d want start=%0d", ok, cap_start, c0 + 1); end
   endtask

   task automatic test_frame_content();
      logic [31:0] fcs;
      fcs = sw_fcs();
      checks++; if (cap_len != FRAME_LEN) begin errors++; $display("FAIL frame_len: got %0d want %0d", cap_len, FRAME_LEN); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (cap[i] !== ((i == 7) ? 8'hD5 : 8'h55)) begin
            errors++; $display("FAIL preamble[%0d]: got %h want %h", i, cap[i], (i == 7) ? 8'hD5 : 8'h55);
         end
      end
      for (int i = 0; i < 60; i++) begin
         checks++;
         if (cap[8+i] !== exp_payload[i]) begin
            errors++; $display("FAIL payload[%0d]: got %h want %h", i, cap[8+i], exp_payload[i]);
         end
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (cap[68+i] !== fcs[8*i +: 8]) begin
            errors++; $display("FAIL fcs[%0d]: got %h want %h", i, cap[68+i], fcs[8*i +: 8]);
         end
      end
      checks++; if (cap_err) begin errors++; $display("FAIL tx_err_in_frame: got 1 want 0"); end
      for (int i = 0; i < FRAME_LEN; i++) ref_frame[i] = cap[i];
   endtask

   task automatic test_led();
      link_up = 1'b1;
      @(negedge userclk2);
      checks++; if (led_link !== 1'b1) begin errors++; $display("FAIL led_link_rise: got %b want 1", led_link); end
      link_up = 1'b0;
      @(negedge userclk2);
      checks++; if (led_link !== 1'b0) begin errors++; $display("FAIL led_link_fall: got %b want 0", led_link); end
   endtask

   task automatic test_periodic();
      int  prev_start;
      int  prev_end;
      int  diffs;
      bit  ok;
      prev_start = cap_start;
      prev_end   = cap_end;
`ifdef ARP_PERIODIC_EN
      for (int f = 0; f < 3; f++) begin
         capture_frame(2 * PERIOD, -1, ok);
         checks++; if (!ok) begin errors++; $display("FAIL periodic_frame%0d_seen: got none want frame", f); end
         checks++; if (cap_start - prev_start != PERIOD) begin errors++; $display("FAIL periodic_spacing%0d: got %0d want %0d", f, cap_start - prev_start, PERIOD); end
         checks++; if (cap_start - prev_end < IFG) begin errors++; $display("FAIL periodic_ifg%0d: got %0d want >= %0d", f, cap_start - prev_end, IFG); end
         diffs = (cap_len != FRAME_LEN) ? 1 : 0;
         for (int i = 0; i < FRAME_LEN; i++) if (cap[i] !== ref_frame[i]) diffs++;
         checks++; if (diffs != 0) begin errors++; $display("FAIL periodic_identical%0d: got %0d differing bytes want 0", f, diffs); end
         prev_start = cap_start;
         prev_end   = cap_end;
      end
`else
      capture_frame(3 * PERIOD, -1, ok);
      checks++; if (ok) begin errors++; $display("FAIL single_shot_no_repeat: got frame at %0d want none (prev %0d)", cap_start, prev_start); end
`endif
   endtask

   task automatic test_resetdone_drop();
      int k;
      bit ok;
      bit seen;
      reset_release(1'b0, k);
      capture_frame(5, 38, ok);
      checks++; if (!ok || cap_len != FRAME_LEN) begin errors++; $display("FAIL drop_frame_len: got ok=%0d len=%0d want %0d", ok, cap_len, FRAME_LEN); end
      seen = 1'b0;
      for (int i = 0; i < 3 * PERIOD; i++) begin
         @(negedge userclk2);
         if (test_gmii_tx_en) seen = 1'b1;
      end
      checks++; if (seen) begin errors++; $display("FAIL drop_no_new_frame: got tx_en=1 want 0"); end
      resetdone = 1'b1;
      @(negedge userclk2);
`ifdef ARP_PERIODIC_EN
      checks++; if (test_gmii_tx_en !== 1'b1) begin errors++; $display("FAIL drop_resume: got tx_en=%b want 1", test_gmii_tx_en); end
`else
      checks++; if (test_gmii_tx_en !== 1'b0) begin errors++; $display("FAIL drop_resume_single: got tx_en=%b want 0", test_gmii_tx_en); end
`endif
   endtask

   task automatic test_reset_mid_frame();
      int k;
      bit ok;
      int diffs;
      reset_release(1'b0, k);
      repeat (21) @(negedge userclk2);
      checks++; if (test_gmii_tx_en !== 1'b1) begin errors++; $display("FAIL midreset_in_frame: got tx_en=%b want 1", test_gmii_tx_en); end
      #1;
      sys_rst_n = 1'b0;
      #1;
      checks++; if (test_gmii_tx_en !== 1'b0) begin errors++; $display("FAIL midreset_tx_en: got %b want 0", test_gmii_tx_en); end
      checks++; if (phy_rst_n !== 1'b0) begin errors++; $display("FAIL midreset_phy_rst_n: got %b want 0", phy_rst_n); end
      reset_release(1'b0, k);
      checks++; if (k != PHY_RST) begin errors++; $display("FAIL midreset_phy_release: got %0d want %0d", k, PHY_RST); end
      capture_frame(5, -1, ok);
      diffs = (cap_len != FRAME_LEN) ? 1 : 0;
      for (int i = 0; i < FRAME_LEN; i++) if (cap[i] !== ref_frame[i]) diffs++;
      checks++; if (!ok || diffs != 0) begin errors++; $display("FAIL midreset_frame: got ok=%0d diffs=%0d want ok=1 diffs=0", ok, diffs); end
   endtask

   initial begin
      build_expected();
      test_reset();
      test_first_frame();
      test_frame_content();
      test_led();
      test_periodic();
      test_resetdone_drop();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
